// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes,
// ALU operation codes and datapath select values.
package mc_pkg;

   localparam int unsigned STATE_W = 4;
   localparam int unsigned ALUOP_W = 3;

   typedef enum logic [STATE_W-1:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StExec   = 4'd2,
      StMemRd  = 4'd3,
      StMemWr  = 4'd4,
      StWbAlu  = 4'd5,
      StWbMem  = 4'd6,
      StBranch = 4'd7,
      StJump   = 4'd8
   } state_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpLui   = 6'b001111;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpJ     = 6'b000010;

   localparam logic [5:0] FnAddu  = 6'b100001;
   localparam logic [5:0] FnSubu  = 6'b100011;

   localparam logic [ALUOP_W-1:0] AluAnd = 3'b000;
   localparam logic [ALUOP_W-1:0] AluOr  = 3'b001;
   localparam logic [ALUOP_W-1:0] AluAdd = 3'b010;
   localparam logic [ALUOP_W-1:0] AluSub = 3'b011;

   localparam logic [1:0] PcSrcAlu    = 2'b00;
   localparam logic [1:0] PcSrcAluOut = 2'b01;
   localparam logic [1:0] PcSrcJump   = 2'b10;

   localparam logic [1:0] ASelPc   = 2'b00;
   localparam logic [1:0] ASelRs   = 2'b01;
   localparam logic [1:0] ASelZero = 2'b10;

   localparam logic [1:0] BSelRt    = 2'b00;
   localparam logic [1:0] BSelFour  = 2'b01;
   localparam logic [1:0] BSelImm   = 2'b10;
   localparam logic [1:0] BSelImmSh = 2'b11;

   localparam logic [1:0] ExtZero = 2'b00;
   localparam logic [1:0] ExtSign = 2'b01;
   localparam logic [1:0] ExtLui  = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// Opcode/funct decoder: ALU operation for the EXEC cycle and the
// unsupported-instruction flag used in DECODE.
module mc_alu_dec
   import mc_pkg::*;
(
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               illegal
);

   always_comb begin
      alu_op  = AluAnd;
      illegal = 1'b0;
      case (opcode)
         OpRtype: begin
            case (funct)
               FnAddu:  alu_op = AluAdd;
               FnSubu:  alu_op = AluSub;
               default: illegal = 1'b1;
            endcase
         end
         OpOri, OpLui: alu_op = AluOr;
         OpLw, OpSw:   alu_op = AluAdd;
         OpBeq:        alu_op = AluSub;
         OpJ:          alu_op = AluAnd;
         default:      illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM. Optional MC_PERF_CNT_EN adds free-running
// cycle and retired-instruction counters.
module mc_ctrl
   import mc_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_we,
   output logic [1:0]         pc_src,
   output logic               ir_we,
   output logic               mem_re,
   output logic               mem_we,
   output logic               mem_addr_sel,
   output logic               rf_we,
   output logic               rf_dst_sel,
   output logic               rf_wd_sel,
   output logic [1:0]         alu_a_sel,
   output logic [1:0]         alu_b_sel,
   output logic [1:0]         ext_op,
   output logic [ALUOP_W-1:0] ALU_operation,
   output logic               instr_done,
   output logic               illegal,
   output logic [STATE_W-1:0] state
`ifdef MC_PERF_CNT_EN
   ,
   output logic [31:0]        cycle_cnt,
   output logic [31:0]        instr_cnt
`endif
);

   state_e             state_q, state_d;
   logic [ALUOP_W-1:0] dec_alu_op;
   logic               dec_illegal;

   mc_alu_dec u_alu_dec (
      .opcode  (opcode),
      .funct   (funct),
      .alu_op  (dec_alu_op),
      .illegal (dec_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StFetch;
      else        state_q <= state_d;
   end

   assign state = state_q;

   // Fields a state does not name are held at 0.
   always_comb begin
      state_d       = state_q;
      pc_we         = 1'b0;
      pc_src        = PcSrcAlu;
      ir_we         = 1'b0;
      mem_re        = 1'b0;
      mem_we        = 1'b0;
      mem_addr_sel  = 1'b0;
      rf_we         = 1'b0;
      rf_dst_sel    = 1'b0;
      rf_wd_sel     = 1'b0;
      alu_a_sel     = ASelPc;
      alu_b_sel     = BSelRt;
      ext_op        = ExtZero;
      ALU_operation = AluAnd;
      instr_done    = 1'b0;
      illegal       = 1'b0;

      case (state_q)
         StFetch: begin
            mem_re        = 1'b1;
            alu_b_sel     = BSelFour;
            ALU_operation = AluAdd;
            ir_we         = mem_ready;
            pc_we         = mem_ready;
            if (mem_ready) state_d = StDecode;
         end
         StDecode: begin
            // Branch target is computed speculatively into ALUOut.
            alu_b_sel     = BSelImmSh;
            ext_op        = ExtSign;
            ALU_operation = AluAdd;
            if (dec_illegal) begin
               illegal = 1'b1;
               state_d = StFetch;
            end else begin
               case (opcode)
                  OpBeq:   state_d = StBranch;
                  OpJ:     state_d = StJump;
                  default: state_d = StExec;
               endcase
            end
         end
         StExec: begin
            ALU_operation = dec_alu_op;
            case (opcode)
               OpRtype: begin
                  alu_a_sel = ASelRs;
                  alu_b_sel = BSelRt;
                  state_d   = StWbAlu;
               end
               OpOri: begin
                  alu_a_sel = ASelRs;
                  alu_b_sel = BSelImm;
                  ext_op    = ExtZero;
                  state_d   = StWbAlu;
               end
               OpLui: begin
                  alu_a_sel = ASelZero;
                  alu_b_sel = BSelImm;
                  ext_op    = ExtLui;
                  state_d   = StWbAlu;
               end
               OpLw, OpSw: begin
                  alu_a_sel = ASelRs;
                  alu_b_sel = BSelImm;
                  ext_op    = ExtSign;
                  state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
               end
               default: state_d = StFetch;
            endcase
         end
         StMemRd: begin
            mem_re       = 1'b1;
            mem_addr_sel = 1'b1;
            if (mem_ready) state_d = StWbMem;
         end
         StMemWr: begin
            mem_we       = 1'b1;
            mem_addr_sel = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_d    = StFetch;
            end
         end
         StWbAlu: begin
            rf_we      = 1'b1;
            rf_dst_sel = (opcode == OpRtype);
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         StWbMem: begin
            rf_we      = 1'b1;
            rf_wd_sel  = 1'b1;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         StBranch: begin
            alu_a_sel     = ASelRs;
            alu_b_sel     = BSelRt;
            ALU_operation = AluSub;
            pc_src        = PcSrcAluOut;
            pc_we         = zero;
            instr_done    = 1'b1;
            state_d       = StFetch;
         end
         StJump: begin
            pc_src     = PcSrcJump;
            pc_we      = 1'b1;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         default: state_d = StFetch;
      endcase

      // Outputs are quiet for the whole time reset is asserted.
      if (!rst_n) begin
         pc_we         = 1'b0;
         pc_src        = PcSrcAlu;
         ir_we         = 1'b0;
         mem_re        = 1'b0;
         mem_we        = 1'b0;
         mem_addr_sel  = 1'b0;
         rf_we         = 1'b0;
         rf_dst_sel    = 1'b0;
         rf_wd_sel     = 1'b0;
         alu_a_sel     = ASelPc;
         alu_b_sel     = BSelRt;
         ext_op        = ExtZero;
         ALU_operation = AluAnd;
         instr_done    = 1'b0;
         illegal       = 1'b0;
      end
   end

`ifdef MC_PERF_CNT_EN
   logic [31:0] cycle_cnt_q, instr_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_q + 32'd1;
         if (instr_done) instr_cnt_q <= instr_cnt_q + 32'd1;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction expected cycle sequences
// built from the instruction-level rules, directed cases then random ones.
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode, funct;
   logic       zero, mem_ready;
   logic       pc_we, ir_we, mem_re, mem_we, mem_addr_sel;
   logic       rf_we, rf_dst_sel, rf_wd_sel, instr_done, illegal;
   logic [1:0] pc_src, alu_a_sel, alu_b_sel, ext_op;
   logic [2:0] ALU_operation;
   logic [3:0] state;
`ifdef MC_PERF_CNT_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif

   mc_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .funct         (funct),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .pc_we         (pc_we),
      .pc_src        (pc_src),
      .ir_we         (ir_we),
      .mem_re        (mem_re),
      .mem_we        (mem_we),
      .mem_addr_sel  (mem_addr_sel),
      .rf_we         (rf_we),
      .rf_dst_sel    (rf_dst_sel),
      .rf_wd_sel     (rf_wd_sel),
      .alu_a_sel     (alu_a_sel),
      .alu_b_sel     (alu_b_sel),
      .ext_op        (ext_op),
      .ALU_operation (ALU_operation),
      .instr_done    (instr_done),
      .illegal       (illegal),
      .state         (state)
`ifdef MC_PERF_CNT_EN
      ,
      .cycle_cnt     (cycle_cnt),
      .instr_cnt     (instr_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pc_we;
      logic [1:0] pc_src;
      logic       ir_we;
      logic       mem_re;
      logic       mem_we;
      logic       addr_sel;
      logic       rf_we;
      logic       dst_sel;
      logic       wd_sel;
      logic [1:0] asel;
      logic [1:0] bsel;
      logic [1:0] ext;
      logic [2:0] aluop;
      logic       done;
      logic       ill;
   } outs_t;

   typedef struct {
      logic       mr;
      logic [3:0] st;
      outs_t      o;
   } ent_t;

   outs_t obs;
   assign obs = {pc_we, pc_src, ir_we, mem_re, mem_we, mem_addr_sel, rf_we, rf_dst_sel,
                 rf_wd_sel, alu_a_sel, alu_b_sel, ext_op, ALU_operation, instr_done, illegal};

   ent_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc_m  = 0;
   int   instr_m = 0;

   task automatic push(input logic mr, input logic [3:0] st, input outs_t o);
      ent_t e;
      e.mr = mr;
      e.st = st;
      e.o  = o;
      q.push_back(e);
   endtask

   task automatic check_outs(input string tag, input outs_t want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s outs: got %h want %h", tag, obs, want);
      end
   endtask

   task automatic check_state(input string tag, input logic [3:0] want);
      checks++;
      assert (state === want) else begin
         errors++;
         $error("FAIL %s state: got %0d want %0d", tag, state, want);
      end
   endtask

`ifdef MC_PERF_CNT_EN
   task automatic check_cnt(input string tag);
      checks++;
      assert (instr_cnt === 32'(instr_m)) else begin
         errors++;
         $error("FAIL %s instr_cnt: got %0d want %0d", tag, instr_cnt, instr_m);
      end
      checks++;
      assert (cycle_cnt === 32'(cyc_m)) else begin
         errors++;
         $error("FAIL %s cycle_cnt: got %0d want %0d", tag, cycle_cnt, cyc_m);
      end
   endtask
`endif

   // Builds the expected cycle list for one instruction, then steps the DUT
   // through it. abort_after>0 stops before that cycle index (for reset tests).
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int wf, input int wm, input int abort_after);
      outs_t o;
      logic  legal;
      string tag;
      q.delete();

      for (int k = 0; k < wf; k++) begin
         o = '0; o.mem_re = 1; o.bsel = 2'b01; o.aluop = 3'b010;
         push(1'b0, 4'd0, o);
      end
      o = '0; o.mem_re = 1; o.bsel = 2'b01; o.aluop = 3'b010; o.ir_we = 1; o.pc_we = 1;
      push(1'b1, 4'd0, o);

      legal = (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) ||
              op == 6'h0d || op == 6'h0f || op == 6'h23 || op == 6'h2b ||
              op == 6'h04 || op == 6'h02;
      o = '0; o.bsel = 2'b11; o.ext = 2'b01; o.aluop = 3'b010; o.ill = !legal;
      push(1'($urandom_range(0, 1)), 4'd1, o);

      if (legal) begin
         if (op == 6'h04) begin
            o = '0; o.asel = 2'b01; o.aluop = 3'b011; o.pc_src = 2'b01; o.pc_we = z;
            o.done = 1;
            push(1'($urandom_range(0, 1)), 4'd7, o);
         end else if (op == 6'h02) begin
            o = '0; o.pc_src = 2'b10; o.pc_we = 1; o.done = 1;
            push(1'($urandom_range(0, 1)), 4'd8, o);
         end else begin
            o = '0;
            case (op)
               6'h00: begin o.asel = 2'b01; o.aluop = (fn == 6'h21) ? 3'b010 : 3'b011; end
               6'h0d: begin o.asel = 2'b01; o.bsel = 2'b10; o.aluop = 3'b001; end
               6'h0f: begin o.asel = 2'b10; o.bsel = 2'b10; o.ext = 2'b10; o.aluop = 3'b001; end
               default: begin o.asel = 2'b01; o.bsel = 2'b10; o.ext = 2'b01; o.aluop = 3'b010; end
            endcase
            push(1'($urandom_range(0, 1)), 4'd2, o);
            if (op == 6'h23) begin
               o = '0; o.mem_re = 1; o.addr_sel = 1;
               for (int k = 0; k < wm; k++) push(1'b0, 4'd3, o);
               push(1'b1, 4'd3, o);
               o = '0; o.rf_we = 1; o.wd_sel = 1; o.done = 1;
               push(1'($urandom_range(0, 1)), 4'd6, o);
            end else if (op == 6'h2b) begin
               o = '0; o.mem_we = 1; o.addr_sel = 1;
               for (int k = 0; k < wm; k++) push(1'b0, 4'd4, o);
               o.done = 1;
               push(1'b1, 4'd4, o);
            end else begin
               o = '0; o.rf_we = 1; o.dst_sel = (op == 6'h00); o.done = 1;
               push(1'($urandom_range(0, 1)), 4'd5, o);
            end
         end
      end

      for (int i = 0; i < q.size(); i++) begin
         if (abort_after > 0 && i == abort_after) break;
         @(negedge clk);
         opcode    = op;
         funct     = fn;
         zero      = z;
         mem_ready = q[i].mr;
         #1;
         tag = $sformatf("op%02h/fn%02h cyc%0d", op, fn, i);
         check_state(tag, q[i].st);
         check_outs(tag, q[i].o);
         if (q[i].o.done) instr_m++;
         cyc_m++;
      end
   endtask

   logic [5:0] ops [8];
   logic [5:0] rop, rfn;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ops = '{6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h00};
      rst_n = 1'b0; opcode = 6'h00; funct = 6'h21; zero = 1'b0; mem_ready = 1'b1;
      #23;
      check_state("reset", 4'd0);
      check_outs("reset", '0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      run_instr(6'h00, 6'h21, 1'b0, 0, 0, 0);  // addu
      run_instr(6'h23, 6'h00, 1'b0, 0, 2, 0);  // lw, two memory waits
      run_instr(6'h04, 6'h00, 1'b1, 0, 0, 0);  // beq taken
      run_instr(6'h04, 6'h00, 1'b0, 0, 0, 0);  // beq not taken
      run_instr(6'h0d, 6'h15, 1'b0, 0, 0, 0);  // ori
      run_instr(6'h0f, 6'h00, 1'b0, 0, 0, 0);  // lui
      run_instr(6'h3f, 6'h00, 1'b0, 0, 0, 0);  // illegal opcode
`ifdef MC_PERF_CNT_EN
      check_cnt("after_illegal");
`endif
      run_instr(6'h2b, 6'h00, 1'b0, 1, 1, 0);  // sw with waits
      run_instr(6'h02, 6'h00, 1'b0, 0, 0, 0);  // j
      run_instr(6'h00, 6'h20, 1'b0, 0, 0, 0);  // R-type, unsupported funct
      run_instr(6'h00, 6'h23, 1'b0, 2, 0, 0);  // subu with fetch waits

      // Reset in the middle of EXEC must abort the instruction at once.
      run_instr(6'h00, 6'h21, 1'b0, 0, 0, 3);
      #2 rst_n = 1'b0;
      #1;
      check_state("mid_exec_reset", 4'd0);
      check_outs("mid_exec_reset", '0);
      cyc_m = 0;
      instr_m = 0;
`ifdef MC_PERF_CNT_EN
      check_cnt("mid_exec_reset");
`endif
      @(posedge clk);
      #2 rst_n = 1'b1;

      for (int n = 0; n < 60; n++) begin
         rop = ops[$urandom_range(0, 7)];
         if ($urandom_range(0, 9) == 0) rop = 6'($urandom);
         case ($urandom_range(0, 2))
            0:       rfn = 6'h21;
            1:       rfn = 6'h23;
            default: rfn = 6'($urandom);
         endcase
         run_instr(rop, rfn, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   $urandom_range(0, 3), 0);
      end

      @(negedge clk);
      #1;
`ifdef MC_PERF_CNT_EN
      check_cnt("final");
`endif
      check_state("final", 4'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle MIPS control FSM; the producer of the 3-bit ALU operation code and the consumer of the ALU zero flag.
Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives all datapath enables and selects.
Handshakes with instruction/data memory through mem_ready.
Sits between the IR opcode/funct fields and the multi-cycle datapath (PC, IR, regfile, ALU, ALUOut, MDR).

Parameters:
STATE_W, 4, state register width (fixed by package encoding)
ALUOP_W, 3, ALU operation width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], stable from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current read/write this cycle
pc_we  out  1  PC write enable
pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
ir_we  out  1  IR load enable
mem_re  out  1  memory read request
mem_we  out  1  memory write request
mem_addr_sel  out  1  0 PC, 1 ALUOut
rf_we  out  1  regfile write enable
rf_dst_sel  out  1  0 rt, 1 rd
rf_wd_sel  out  1  0 ALUOut, 1 MDR
alu_a_sel  out  2  00 PC, 01 rs, 10 zero
alu_b_sel  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
ext_op  out  2  00 zero-ext, 01 sign-ext, 10 imm<<16
ALU_operation  out  3  000 AND, 001 OR, 010 ADD, 011 SUB
instr_done  out  1  one-cycle pulse on final cycle of each instruction
illegal  out  1  one-cycle pulse on unsupported opcode/funct
state  out  4  current state, for debug

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. rst_n low forces state=FETCH; while rst_n is low all enables/requests/pulses are 0 and selects are 0.
- Supported: addu (op 0, funct 100001), subu (op 0, funct 100011), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010.
- Outputs are combinational from state, plus opcode/funct in EXEC/WB and zero in BRANCH. State is the only register.
- FETCH: mem_re=1, mem_addr_sel=0, alu_a=PC, alu_b=4, ADD. ir_we=pc_we=mem_ready, pc_src=00. Hold while !mem_ready, then go to DECODE.
- DECODE: alu_a=PC, alu_b=imm<<2, ext sign, ADD (branch target into ALUOut). Next state: R-type/ori/lui/lw/sw go to EXEC; beq goes to BRANCH; j goes to JUMP; otherwise pulse illegal, go to FETCH.
- EXEC:
  - R-type: alu_a=rs, alu_b=rt, ADD (addu) or SUB (subu).
  - ori: rs, imm zero-ext, OR.
  - lui: alu_a=zero, ext_op=10, OR.
  - lw/sw: rs, sign-ext imm, ADD.
  - Next state: R/ori/lui go to WB_ALU; lw goes to MEM_RD; sw goes to MEM_WR.
- MEM_RD: mem_re=1, mem_addr_sel=1. Hold until mem_ready, then go to WB_MEM.
- MEM_WR: mem_we=1, mem_addr_sel=1. Hold until mem_ready; on the ready cycle instr_done=1 and next state is FETCH.
- WB_ALU: rf_we=1, rf_wd_sel=0, rf_dst_sel=1 for R-type, 0 for ori/lui. instr_done=1, go to FETCH.
- WB_MEM: rf_we=1, rf_wd_sel=1, rf_dst_sel=0. instr_done=1, go to FETCH.
- BRANCH: alu_a=rs, alu_b=rt, SUB, pc_src=01, pc_we=zero. instr_done=1, go to FETCH.
- JUMP: pc_src=10, pc_we=1, instr_done=1, go to FETCH.
- Cycle counts with zero wait: R/ori/lui 4, lw 5, sw 4, beq 3, j 3. Each !mem_ready cycle adds one cycle.
- Request/enable rules:
  - mem_re/mem_we held constant until mem_ready; never both high.
  - rf_we and pc_we are never high in a memory-wait cycle.
- An undefined state encoding recovers to FETCH on the next clock.
- Reset mid-instruction aborts it immediately; there is no partial writeback after rst_n deasserts.

Optional Feature:
MC_PERF_CNT_EN.
- Defined: adds 32-bit outputs cycle_cnt (increments every non-reset cycle) and instr_cnt (increments on instr_done). Both reset to 0 and wrap at 2^32-1 to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
Package mc_pkg holds:
- state encoding constants (FETCH=0, DECODE=1, EXEC=2, MEM_RD=3, MEM_WR=4, WB_ALU=5, WB_MEM=6, BRANCH=7, JUMP=8)
- opcode/funct constants
- ALU op codes AND/OR/ADD/SUB = 000/001/010/011
- select encodings

One sub-module, mc_alu_dec: combinational opcode/funct to ALU_operation and illegal for the EXEC state.

Test Plan:
- Reset: rst_n=0 mid-EXEC -> state=FETCH and all enables 0 asynchronously; after release, first cycle mem_re=1, ALU_operation=010.
- addu (op 0, funct 100001), mem_ready=1 -> states FETCH,DECODE,EXEC(ALU_operation=010),WB_ALU(rf_we=1, rf_dst_sel=1); instr_done on cycle 4.
- lw with mem_ready low 2 cycles in MEM_RD -> mem_re held 3 cycles, WB_MEM rf_wd_sel=1; total 7 cycles.
- beq, zero=1 -> BRANCH ALU_operation=011, pc_we=1, pc_src=01. Repeat with zero=0 -> pc_we=0; both take 3 cycles.
- ori then lui -> EXEC ALU_operation=001 with ext_op=00 then ext_op=10, alu_a_sel=10; rf_dst_sel=0.
- opcode 111111 -> illegal pulse in DECODE, back to FETCH, no rf_we/mem_we. With MC_PERF_CNT_EN, instr_cnt unchanged.
